rst_req_ctrl: RTL and testbench

- Initiator end of the reset protocol: collects reset requests (software, watchdog, board button) and drives the active-low reset input of the reset generator.
- Waits for the generator to complete its stretch/release sequence, then enforces a hold-off window.
- Clocked and reset from the always-on power-on domain, never from the reset it requests.

---
 rtl/rst_req_ctrl.sv | 153 +++++++++++++++
 tb/tb_rst_req_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset-request initiator: merges SW/WDT/button requests into one active-low pulse toward the reset
// generator, waits for its release and then holds off. Optional release timeout: RSTREQ_TIMEOUT_EN.
module rst_req_ctrl #(
   parameter int PULSE_W  = 16,
   parameter int DEBOUNCE = 1000,
   parameter int HOLDOFF  = 64,
   parameter int TIMEOUT  = 4096
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_SW,
   input  logic       REQ_WDT,
   input  logic       REQ_BTN,
   input  logic       RST_DONE_I,
   output logic       RST_REQ_X_O,
   output logic       BUSY,
   output logic [2:0] CAUSE,
   output logic [7:0] REQ_CNT,
   output logic       ERR
);

   localparam int MAX_AB = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
   localparam int MAX_CD = (DEBOUNCE > TIMEOUT) ? DEBOUNCE : TIMEOUT;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_P) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_REL, S_HOLDOFF} state_t;

   state_t          state, state_n;
   logic            btn_meta, btn_sync, btn_fired, btn_evt;
   logic [CW-1:0]   deb_cnt;
   logic [CW-1:0]   cnt;
   logic [2:0]      req_vec, pending, cause_acc;
   logic            seen_low, rel_ok, timeout_hit;

   // Button is asynchronous: synchronise, then require DEBOUNCE steady high samples for one event
   always_ff @(posedge CLK) begin
      if (RST) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         btn_fired <= 1'b0;
         btn_evt   <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         btn_meta <= REQ_BTN;
         btn_sync <= btn_meta;
         btn_evt  <= 1'b0;
         if (!btn_sync) begin
            deb_cnt   <= '0;
            btn_fired <= 1'b0;
         end else if (!btn_fired) begin
            if (deb_cnt == CW'(DEBOUNCE - 1)) begin
               btn_evt   <= 1'b1;
               btn_fired <= 1'b1;
            end else begin
               deb_cnt <= deb_cnt + CW'(1);
            end
         end
      end
   end

   assign req_vec = {btn_evt, REQ_WDT, REQ_SW};
   assign rel_ok  = seen_low && RST_DONE_I;

`ifdef RSTREQ_TIMEOUT_EN
   logic [CW-1:0] to_cnt;

   assign timeout_hit = (to_cnt == CW'(TIMEOUT - 1));

   // Sticky error when the generator never releases within TIMEOUT WAIT_REL cycles
   always_ff @(posedge CLK) begin
      if (RST) begin
         to_cnt <= '0;
         ERR    <= 1'b0;
      end else if (state == S_WAIT_REL) begin
         to_cnt <= to_cnt + CW'(1);
         if (timeout_hit && !rel_ok)
            ERR <= 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign ERR         = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:     if ((|pending) || (|req_vec)) state_n = S_ASSERT;
         S_ASSERT:   if (cnt == '0) state_n = S_WAIT_REL;
         S_WAIT_REL: if (rel_ok || timeout_hit) state_n = S_HOLDOFF;
         S_HOLDOFF:  if (cnt == '0) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   always_comb begin
      RST_REQ_X_O = (state != S_ASSERT);
      BUSY        = (state != S_IDLE);
   end

   // Requests outside ASSERT are deferred into pending; inside ASSERT they merge into the current service
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending   <= '0;
         cause_acc <= '0;
         cnt       <= '0;
         seen_low  <= 1'b0;
         CAUSE     <= '0;
         REQ_CNT   <= '0;
      end else begin
         if (state != S_ASSERT)
            pending <= pending | req_vec;
         case (state)
            S_IDLE: begin
               if (state_n == S_ASSERT) begin
                  cause_acc <= pending | req_vec;
                  pending   <= '0;
                  cnt       <= CW'(PULSE_W - 1);
                  seen_low  <= 1'b0;
               end
            end
            S_ASSERT: begin
               cause_acc <= cause_acc | req_vec;
               if (!RST_DONE_I) seen_low <= 1'b1;
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            S_WAIT_REL: begin
               if (!RST_DONE_I) seen_low <= 1'b1;
               if (state_n == S_HOLDOFF) begin
                  CAUSE <= cause_acc;
                  if (REQ_CNT != 8'hFF) REQ_CNT <= REQ_CNT + 8'd1;
                  cnt <= CW'(HOLDOFF - 1);
               end
            end
            S_HOLDOFF: begin
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl with a reset-generator model and an expected-service scoreboard.
// The release-timeout section adapts to RSTREQ_TIMEOUT_EN.
module tb_rst_req_ctrl;

   logic       CLK = 1'b0;
   logic       RST, REQ_SW, REQ_WDT, REQ_BTN, RST_DONE_I;
   logic       RST_REQ_X_O, BUSY, ERR;
   logic [2:0] CAUSE;
   logic [7:0] REQ_CNT;

   typedef struct packed {
      logic [2:0] cause;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   int   pulse_cnt = 0;
   int   low_run = 0;
   int   last_width = 0;
   int   pulses0, n;
   logic gen_en;
   logic [4:0] bounce;

   rst_req_ctrl #(.PULSE_W(16), .DEBOUNCE(8), .HOLDOFF(64), .TIMEOUT(32)) dut (
      .CLK(CLK), .RST(RST), .REQ_SW(REQ_SW), .REQ_WDT(REQ_WDT), .REQ_BTN(REQ_BTN),
      .RST_DONE_I(RST_DONE_I), .RST_REQ_X_O(RST_REQ_X_O), .BUSY(BUSY),
      .CAUSE(CAUSE), .REQ_CNT(REQ_CNT), .ERR(ERR)
   );

   initial forever #5 CLK = ~CLK;

   // Generator model: done goes low while the request is low and stays low 4 cycles after it rises
   initial begin
      int hold;
      hold = 0;
      RST_DONE_I = 1'b1;
      forever begin
         @(posedge CLK); #1;
         if (!gen_en) begin
            RST_DONE_I = 1'b1;
            hold = 0;
         end else if (RST_REQ_X_O === 1'b0) begin
            RST_DONE_I = 1'b0;
            hold = 4;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) RST_DONE_I = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge CLK);
      if (RST_REQ_X_O === 1'b0) low_run++;
      else if (low_run != 0) begin
         last_width = low_run;
         pulse_cnt++;
         low_run = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic applyStimulus(input logic sw, input logic wdt);
      REQ_SW = sw;
      REQ_WDT = wdt;
      tick(1);
      REQ_SW = 1'b0;
      REQ_WDT = 1'b0;
   endtask

   task automatic pushExpected(input logic [2:0] c);
      exp_t e;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      e.cause = c;
      e.cnt = 8'(exp_cnt);
      sb.push_back(e);
   endtask

   task automatic waitService(input string tag, input int limit);
      logic [7:0] start;
      int k;
      exp_t e;
      start = REQ_CNT;
      k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while (REQ_CNT === start && k < limit);
      checkOutput({tag, "_wait"}, (REQ_CNT === start), 0);
      checkOutput({tag, "_sb"}, sb.size(), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput({tag, "_cause"}, CAUSE, e.cause);
         checkOutput({tag, "_cnt"}, REQ_CNT, e.cnt);
      end
   endtask

   task automatic waitIdle(input string tag, input int limit, output int cycles);
      cycles = 0;
      while (BUSY === 1'b1 && cycles < limit) begin
         cycles++;
         @(negedge CLK);
      end
      checkOutput({tag, "_idle_wait"}, (cycles >= limit), 0);
   endtask

   initial begin
      RST = 1'b1; REQ_SW = 1'b0; REQ_WDT = 1'b0; REQ_BTN = 1'b0; gen_en = 1'b1;
      tick(3);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst_req", RST_REQ_X_O, 1);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_cause", CAUSE, 0);
      checkOutput("rst_cnt", REQ_CNT, 0);
      checkOutput("rst_err", ERR, 0);

      // Single software request: one-cycle latency, 16-cycle pulse, 64-cycle hold-off
      tick(1);
      pulses0 = pulse_cnt;
      REQ_SW = 1'b1;
      pushExpected(3'b001);
      @(negedge CLK);
      checkOutput("sw_pre", RST_REQ_X_O, 1);
      @(posedge CLK); #1;
      REQ_SW = 1'b0;
      @(negedge CLK);
      checkOutput("sw_latency", RST_REQ_X_O, 0);
      checkOutput("sw_busy", BUSY, 1);
      waitService("sw", 200);
      checkOutput("sw_width", last_width, 16);
      checkOutput("sw_pulses", pulse_cnt - pulses0, 1);
      checkOutput("sw_hold_busy", BUSY, 1);
      waitIdle("sw", 200, n);
      checkOutput("sw_holdoff_len", n, 64);

      // Simultaneous SW+WDT, extra WDT during ASSERT merges into the same service
      tick(1);
      pulses0 = pulse_cnt;
      pushExpected(3'b011);
      applyStimulus(1'b1, 1'b1);
      tick(5);
      applyStimulus(1'b0, 1'b1);
      waitService("sim", 200);
      checkOutput("sim_width", last_width, 16);
      checkOutput("sim_pulses", pulse_cnt - pulses0, 1);

      // WDT during hold-off is deferred and serviced right after IDLE is re-entered
      tick(3);
      pulses0 = pulse_cnt;
      pushExpected(3'b010);
      applyStimulus(1'b0, 1'b1);
      @(negedge CLK);
      checkOutput("def_hold_req", RST_REQ_X_O, 1);
      checkOutput("def_hold_busy", BUSY, 1);
      waitIdle("def", 200, n);
      checkOutput("def_idle_req", RST_REQ_X_O, 1);
      @(negedge CLK);
      checkOutput("def_start_req", RST_REQ_X_O, 0);
      checkOutput("def_start_busy", BUSY, 1);
      waitService("def", 200);
      checkOutput("def_pulses", pulse_cnt - pulses0, 1);
      waitIdle("def2", 200, n);

      // Bouncing button then held high: exactly one press event
      tick(1);
      pulses0 = pulse_cnt;
      pushExpected(3'b100);
      bounce = 5'b10110;
      for (int i = 4; i >= 0; i--) begin
         REQ_BTN = bounce[i];
         tick(1);
      end
      REQ_BTN = 1'b1;
      tick(20);
      waitService("btn", 300);
      checkOutput("btn_width", last_width, 16);
      waitIdle("btn", 200, n);
      tick(40);
      @(negedge CLK);
      checkOutput("btn_pulses", pulse_cnt - pulses0, 1);
      checkOutput("btn_hold_cnt", REQ_CNT, exp_cnt);
      checkOutput("btn_hold_busy", BUSY, 0);
      REQ_BTN = 1'b0;
      tick(5);

      // Generator never drops done: the sequence must not complete by itself
      gen_en = 1'b0;
      tick(1);
      applyStimulus(1'b1, 1'b0);
`ifdef RSTREQ_TIMEOUT_EN
      pushExpected(3'b001);
      waitService("to", 200);
      checkOutput("to_err", ERR, 1);
      waitIdle("to", 200, n);
      checkOutput("to_err_sticky", ERR, 1);
`else
      tick(200);
      @(negedge CLK);
      checkOutput("stuck_busy", BUSY, 1);
      checkOutput("stuck_err", ERR, 0);
      checkOutput("stuck_cnt", REQ_CNT, exp_cnt);
      checkOutput("stuck_req", RST_REQ_X_O, 1);
`endif

      // Reset wins over a simultaneous request
      RST = 1'b1;
      REQ_SW = 1'b1;
      tick(1);
      RST = 1'b0;
      REQ_SW = 1'b0;
      gen_en = 1'b1;
      exp_cnt = 0;
      @(negedge CLK);
      checkOutput("rst2_req", RST_REQ_X_O, 1);
      checkOutput("rst2_busy", BUSY, 0);
      checkOutput("rst2_cnt", REQ_CNT, 0);
      checkOutput("rst2_cause", CAUSE, 0);
      checkOutput("rst2_err", ERR, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
